id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS pipeline; consumes the branch/operand forwarding selects (ALUSrcE for rs, ALUSrcF for rt).
- At capture, picks each operand from the register file, Mem-stage result or Wr-stage result.
- Detects load-use hazards and inserts bubbles.
- Honours external stall/flush.
- Feeds the EX stage and the forwarding/hazard units downstream.

Parameters:
- DATA_W, 32, operand/immediate/PC width
- REG_W, 5, register index width
- ALUCTR_W, 3, ALU control field width

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  DATA_W  PC+4 of ID instruction
- id_rs, id_rt, id_rd  in  REG_W  register fields
- id_imm  in  DATA_W  extended immediate
- id_rd1, id_rd2  in  DATA_W  register-file read data (rs, rt)
- id_RegWr, id_MemWr, id_MemtoReg, id_ALUSrc, id_RegDst, id_Branch  in  1 each  decoded controls
- id_ALUctr  in  ALUCTR_W  ALU operation
- ALUSrcE, ALUSrcF  in  2  forward selects for rs/rt: 00 regfile, 01 Mem result, 10 Wr result, 11 regfile
- mem_fwd_data, wr_fwd_data  in  DATA_W  Mem-stage ALU result, Wr-stage writeback data
- stall  in  1  external hold (e.g. memory wait)
- flush  in  1  kill ID->EX transfer (taken branch)
- lu_stall  out  1  combinational load-use stall request to PC/IF-ID
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_imm, ex_busA, ex_busB  out  DATA_W  registered PC, immediate, resolved operands
- ex_rs, ex_rt, ex_rd  out  REG_W
- ex_RegWr, ex_MemWr, ex_MemtoReg, ex_ALUSrc, ex_RegDst, ex_Branch  out  1 each
- ex_ALUctr  out  ALUCTR_W

Behaviour:
- All ex_* outputs are registered and clear to 0 on rst; ex_valid resets to 0.
- Latency is 1 cycle ID->EX.
- lu_stall = id_valid & ex_valid & ex_MemtoReg & ex_RegWr & (ex_rt!=0) & (ex_rt==id_rs | ex_rt==id_rt). It is purely combinational and independent of stall/flush.
- Per-edge priority: rst > flush > lu_stall > stall > capture.
  - flush: load bubble (ex_valid=0, all ex_* controls 0, data fields 0).
  - lu_stall: load bubble; upstream holds ID, so the instruction re-presents and is captured the next cycle with Mem forwarding.
  - stall: all ex_* hold, including operands; a held instruction's later hazards are resolved by the EX-stage forwarding unit.
  - capture: ex_busA = mux(ALUSrcE), ex_busB = mux(ALUSrcF); all other fields copy through.
- Encoding 11 on a select behaves as 00 (regfile); no error is raised.
- flush with lu_stall: bubble, lu_stall still asserted.
- id_valid=0 captured: ex_valid=0 and controls forced to 0 (no stray RegWr/MemWr).
- rst mid-stall: next edge yields reset state regardless of stall/flush.
- Bubble invariant: ex_valid=0 implies ex_RegWr=ex_MemWr=ex_Branch=0.

Optional Feature:
- Macro ID_EX_STATS_EN.
- When defined:
  - Adds outputs bubble_cnt and flush_cnt, each 16 bits, saturating at 16'hFFFF and cleared by rst.
  - bubble_cnt increments on each lu_stall bubble.
  - flush_cnt increments on each flush edge.
  - A flush with lu_stall on the same edge counts as flush only.
- When not defined: no extra ports or logic; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg: FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WR=2'b10 constants; DATA_W/REG_W/ALUCTR_W defaults; packed ctrl bundle typedef (RegWr, MemWr, MemtoReg, ALUSrc, RegDst, Branch, ALUctr) plus CTRL_BUBBLE constant.
- One sub-module, fwd_operand_mux: 2-bit select, three DATA_W inputs, one output; instantiated twice (rs, rt).
- Load-use compare stays inline.

Test Plan:
- Reset: rst=1 with any inputs, 2 edges -> ex_valid=0, all ex_* = 0, lu_stall=0 once ex_valid=0.
- Forward: id_rd1=0x11, mem_fwd_data=0x22, wr_fwd_data=0x33, ALUSrcE=01, ALUSrcF=10 -> next cycle ex_busA=0x22, ex_busB=0x33; with selects 11 -> 0x11 / id_rd2.
- Load-use: EX holds lw (MemtoReg=1, RegWr=1, ex_rt=8); ID add with rs=8 -> lu_stall=1 that cycle, next ex_valid=0 with RegWr=0; re-presented add captured the following cycle.
- Load-use on $0: EX lw with ex_rt=0, ID rs=0 -> lu_stall=0, normal capture.
- Stall/flush: stall=1 for 3 cycles -> ex_* unchanged; then flush=1 with stall=1 -> bubble (flush wins).
- Stats (ID_EX_STATS_EN): 2 load-use bubbles + 1 flush + 1 simultaneous flush/lu_stall -> bubble_cnt=2, flush_cnt=2.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the MIPS ID/EX pipeline register and its
// operand forwarding mux.
//   - Default DATA_W / REG_W / ALUCTR_W widths.
//   - Forward-select encodings FWD_RF / FWD_MEM / FWD_WR.
//   - Packed decoded-control bundle ctrl_t and its all-zero bubble value.
package pipe_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int ALUCTR_W = 3;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WR  = 2'b10;

  typedef struct packed {
    logic                RegWr;
    logic                MemWr;
    logic                MemtoReg;
    logic                ALUSrc;
    logic                RegDst;
    logic                Branch;
    logic [ALUCTR_W-1:0] ALUctr;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/fwd_operand_mux.sv
// fwd_operand_mux: chooses one ID-stage operand from the register file, the
// Mem-stage result or the Wr-stage result.
// Ports:
//   sel      in  2       forward select (00 regfile, 01 Mem, 10 Wr, 11 regfile)
//   rf_data  in  DATA_W  register-file read data
//   mem_data in  DATA_W  Mem-stage ALU result
//   wr_data  in  DATA_W  Wr-stage writeback data
//   y        out DATA_W  selected operand
module fwd_operand_mux
  import pipe_pkg::*;
#(
  parameter int DATA_W = pipe_pkg::DATA_W
) (
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] rf_data,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] y
);

  // 11 is unused and falls back to the register file.
  always_comb begin
    case (sel)
      FWD_MEM: y = mem_data;
      FWD_WR:  y = wr_data;
      default: y = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 5-stage MIPS pipeline.
// Resolves rs/rt operands through the forwarding muxes at capture, detects
// load-use hazards (inserting a bubble), and honours external stall/flush.
// Edge priority: rst > flush > lu_stall > stall > capture.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   id_*                           ID-stage instruction fields, data, controls
//   ALUSrcE, ALUSrcF               forward selects for rs / rt
//   mem_fwd_data, wr_fwd_data      forwarding sources
//   stall, flush                   external hold / kill
//   lu_stall                       combinational load-use stall request
//   ex_*                           registered EX-stage fields
// Optional: define ID_EX_STATS_EN to add saturating 16-bit counters
//   bubble_cnt (load-use bubbles) and flush_cnt (flush edges).
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W   = pipe_pkg::DATA_W,
  parameter int REG_W    = pipe_pkg::REG_W,
  parameter int ALUCTR_W = pipe_pkg::ALUCTR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [DATA_W-1:0]   id_pc,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic [REG_W-1:0]    id_rd,
  input  logic [DATA_W-1:0]   id_imm,
  input  logic [DATA_W-1:0]   id_rd1,
  input  logic [DATA_W-1:0]   id_rd2,
  input  logic                id_RegWr,
  input  logic                id_MemWr,
  input  logic                id_MemtoReg,
  input  logic                id_ALUSrc,
  input  logic                id_RegDst,
  input  logic                id_Branch,
  input  logic [ALUCTR_W-1:0] id_ALUctr,
  input  logic [1:0]          ALUSrcE,
  input  logic [1:0]          ALUSrcF,
  input  logic [DATA_W-1:0]   mem_fwd_data,
  input  logic [DATA_W-1:0]   wr_fwd_data,
  input  logic                stall,
  input  logic                flush,
  output logic                lu_stall,
  output logic                ex_valid,
  output logic [DATA_W-1:0]   ex_pc,
  output logic [DATA_W-1:0]   ex_imm,
  output logic [DATA_W-1:0]   ex_busA,
  output logic [DATA_W-1:0]   ex_busB,
  output logic [REG_W-1:0]    ex_rs,
  output logic [REG_W-1:0]    ex_rt,
  output logic [REG_W-1:0]    ex_rd,
  output logic                ex_RegWr,
  output logic                ex_MemWr,
  output logic                ex_MemtoReg,
  output logic                ex_ALUSrc,
  output logic                ex_RegDst,
  output logic                ex_Branch,
  output logic [ALUCTR_W-1:0] ex_ALUctr
`ifdef ID_EX_STATS_EN
  ,
  output logic [15:0]         bubble_cnt,
  output logic [15:0]         flush_cnt
`endif
);

  ctrl_t             id_ctrl;
  ctrl_t             ex_ctrl;
  logic [DATA_W-1:0] bus_a;
  logic [DATA_W-1:0] bus_b;

  assign id_ctrl = '{RegWr: id_RegWr, MemWr: id_MemWr, MemtoReg: id_MemtoReg,
                     ALUSrc: id_ALUSrc, RegDst: id_RegDst, Branch: id_Branch,
                     ALUctr: id_ALUctr};

  fwd_operand_mux #(.DATA_W(DATA_W)) u_mux_rs (
    .sel      (ALUSrcE),
    .rf_data  (id_rd1),
    .mem_data (mem_fwd_data),
    .wr_data  (wr_fwd_data),
    .y        (bus_a)
  );

  fwd_operand_mux #(.DATA_W(DATA_W)) u_mux_rt (
    .sel      (ALUSrcF),
    .rf_data  (id_rd2),
    .mem_data (mem_fwd_data),
    .wr_data  (wr_fwd_data),
    .y        (bus_b)
  );

  // A load in EX whose destination ($0 excluded) feeds the ID instruction.
  assign lu_stall = id_valid & ex_valid & ex_ctrl.MemtoReg & ex_ctrl.RegWr &
                    (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

  always_ff @(posedge clk) begin
    if (rst || flush || lu_stall) begin
      ex_valid <= 1'b0;
      ex_pc    <= '0;
      ex_imm   <= '0;
      ex_busA  <= '0;
      ex_busB  <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
      ex_ctrl  <= CTRL_BUBBLE;
    end else if (!stall) begin
      ex_valid <= id_valid;
      ex_pc    <= id_pc;
      ex_imm   <= id_imm;
      ex_busA  <= bus_a;
      ex_busB  <= bus_b;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_rd    <= id_rd;
      // An empty ID slot must not carry stray write enables into EX.
      ex_ctrl  <= id_valid ? id_ctrl : CTRL_BUBBLE;
    end
  end

  assign ex_RegWr    = ex_ctrl.RegWr;
  assign ex_MemWr    = ex_ctrl.MemWr;
  assign ex_MemtoReg = ex_ctrl.MemtoReg;
  assign ex_ALUSrc   = ex_ctrl.ALUSrc;
  assign ex_RegDst   = ex_ctrl.RegDst;
  assign ex_Branch   = ex_ctrl.Branch;
  assign ex_ALUctr   = ex_ctrl.ALUctr;

`ifdef ID_EX_STATS_EN
  // A flush coinciding with a load-use hazard counts only as a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (flush && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;
      if (!flush && lu_stall && bubble_cnt != 16'hFFFF)
        bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven bench for id_ex_stage. Each vector drives one
// cycle of ID inputs, checks lu_stall before the edge, pushes the expected
// EX-register contents to a scoreboard queue and pops/compares them after the
// edge. With ID_EX_STATS_EN defined the counters are checked as well.
module tb_id_ex_stage;
  import pipe_pkg::*;

  localparam logic [8:0] C_LW  = 9'b1011_00_010;
  localparam logic [8:0] C_ADD = 9'b1000_10_010;
  localparam logic [8:0] C_SW  = 9'b0101_00_010;

  localparam logic [31:0] D_RD1 = 32'h11;
  localparam logic [31:0] D_RD2 = 32'h44;
  localparam logic [31:0] D_MEM = 32'h22;
  localparam logic [31:0] D_WR  = 32'h33;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, id_valid, stall, flush;
  logic [31:0] id_pc, id_imm, id_rd1, id_rd2, mem_fwd_data, wr_fwd_data;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_RegWr, id_MemWr, id_MemtoReg, id_ALUSrc, id_RegDst, id_Branch;
  logic [2:0]  id_ALUctr;
  logic [1:0]  ALUSrcE, ALUSrcF;
  logic        lu_stall, ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_busA, ex_busB;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_RegWr, ex_MemWr, ex_MemtoReg, ex_ALUSrc, ex_RegDst, ex_Branch;
  logic [2:0]  ex_ALUctr;
`ifdef ID_EX_STATS_EN
  logic [15:0] bubble_cnt, flush_cnt;
`endif

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
    .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_RegWr(id_RegWr), .id_MemWr(id_MemWr), .id_MemtoReg(id_MemtoReg),
    .id_ALUSrc(id_ALUSrc), .id_RegDst(id_RegDst), .id_Branch(id_Branch),
    .id_ALUctr(id_ALUctr), .ALUSrcE(ALUSrcE), .ALUSrcF(ALUSrcF),
    .mem_fwd_data(mem_fwd_data), .wr_fwd_data(wr_fwd_data),
    .stall(stall), .flush(flush), .lu_stall(lu_stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_busA(ex_busA), .ex_busB(ex_busB),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_RegWr(ex_RegWr), .ex_MemWr(ex_MemWr), .ex_MemtoReg(ex_MemtoReg),
    .ex_ALUSrc(ex_ALUSrc), .ex_RegDst(ex_RegDst), .ex_Branch(ex_Branch),
    .ex_ALUctr(ex_ALUctr)
`ifdef ID_EX_STATS_EN
    , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, imm, busA, busB;
    logic [4:0]  rs, rt, rd;
    logic [8:0]  ctrl;
  } exp_t;

  typedef struct {
    logic        rst, stall, flush, valid;
    logic [31:0] pc;
    logic [4:0]  rs, rt, rd;
    logic [8:0]  ctrl;
    logic [1:0]  se, sf;
    logic        exp_lu;
    exp_t        exp;
    logic [15:0] exp_bub, exp_flu;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  vec_t tbl[$];
  exp_t act;

  assign act = '{valid: ex_valid, pc: ex_pc, imm: ex_imm, busA: ex_busA,
                 busB: ex_busB, rs: ex_rs, rt: ex_rt, rd: ex_rd,
                 ctrl: {ex_RegWr, ex_MemWr, ex_MemtoReg, ex_ALUSrc,
                        ex_RegDst, ex_Branch, ex_ALUctr}};

  function automatic logic [31:0] imm_of(input logic [31:0] pc);
    return 32'hF000_0000 | pc;
  endfunction

  function automatic exp_t mkexp(input logic v, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [8:0] c);
    return '{valid: v, pc: pc, imm: imm_of(pc), busA: a, busB: b,
             rs: rs, rt: rt, rd: rd, ctrl: c};
  endfunction

  function automatic vec_t mkv(input logic r, input logic s, input logic f,
                               input logic v, input logic [31:0] pc,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [8:0] c,
                               input logic [1:0] se, input logic [1:0] sf,
                               input logic lu, input exp_t e,
                               input logic [15:0] b, input logic [15:0] fl);
    vec_t x;
    x.rst = r; x.stall = s; x.flush = f; x.valid = v; x.pc = pc;
    x.rs = rs; x.rt = rt; x.rd = rd; x.ctrl = c; x.se = se; x.sf = sf;
    x.exp_lu = lu; x.exp = e; x.exp_bub = b; x.exp_flu = fl;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [152:0] a, input logic [152:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; stall = v.stall; flush = v.flush; id_valid = v.valid;
    id_pc = v.pc; id_imm = imm_of(v.pc);
    id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
    {id_RegWr, id_MemWr, id_MemtoReg, id_ALUSrc, id_RegDst, id_Branch, id_ALUctr} = v.ctrl;
    ALUSrcE = v.se; ALUSrcF = v.sf;
    id_rd1 = D_RD1; id_rd2 = D_RD2; mem_fwd_data = D_MEM; wr_fwd_data = D_WR;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e_v14, e_z;
    e_z   = '0;
    e_v14 = mkexp(1, 32'h12C, D_RD1, D_RD2, 1, 2, 3, C_ADD);
    // rst  stl fl  val pc        rs rt rd ctrl   se     sf     lu exp                                                 bub flu
    tbl.push_back(mkv(1, 1, 0, 1, 32'h200, 8, 8, 8, C_LW,  2'b01, 2'b10, 0, e_z, 0, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 32'h100, 1, 2, 3, C_ADD, 2'b01, 2'b10, 0,
                      mkexp(1, 32'h100, D_MEM, D_WR, 1, 2, 3, C_ADD), 0, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 32'h104, 4, 5, 6, C_ADD, 2'b11, 2'b11, 0,
                      mkexp(1, 32'h104, D_RD1, D_RD2, 4, 5, 6, C_ADD), 0, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 32'h108, 7, 9, 10, C_ADD, 2'b10, 2'b01, 0,
                      mkexp(1, 32'h108, D_WR, D_MEM, 7, 9, 10, C_ADD), 0, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 32'h10C, 1, 8, 0, C_LW, 2'b00, 2'b00, 0,
                      mkexp(1, 32'h10C, D_RD1, D_RD2, 1, 8, 0, C_LW), 0, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 32'h110, 8, 3, 9, C_ADD, 2'b00, 2'b00, 1, e_z, 1, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 32'h110, 8, 3, 9, C_ADD, 2'b01, 2'b00, 0,
                      mkexp(1, 32'h110, D_MEM, D_RD2, 8, 3, 9, C_ADD), 1, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 32'h114, 2, 0, 0, C_LW, 2'b00, 2'b00, 0,
                      mkexp(1, 32'h114, D_RD1, D_RD2, 2, 0, 0, C_LW), 1, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 32'h118, 0, 0, 5, C_ADD, 2'b00, 2'b00, 0,
                      mkexp(1, 32'h118, D_RD1, D_RD2, 0, 0, 5, C_ADD), 1, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 32'h11C, 1, 8, 0, C_LW, 2'b00, 2'b00, 0,
                      mkexp(1, 32'h11C, D_RD1, D_RD2, 1, 8, 0, C_LW), 1, 0));
    tbl.push_back(mkv(0, 1, 0, 1, 32'h120, 2, 8, 0, C_SW, 2'b00, 2'b01, 1, e_z, 2, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 32'h120, 2, 8, 0, C_SW, 2'b00, 2'b01, 0,
                      mkexp(1, 32'h120, D_RD1, D_MEM, 2, 8, 0, C_SW), 2, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 32'h124, 3, 7, 0, C_LW, 2'b00, 2'b00, 0,
                      mkexp(1, 32'h124, D_RD1, D_RD2, 3, 7, 0, C_LW), 2, 0));
    tbl.push_back(mkv(0, 0, 0, 0, 32'h128, 7, 7, 7, C_ADD, 2'b00, 2'b00, 0,
                      mkexp(0, 32'h128, D_RD1, D_RD2, 7, 7, 7, 9'b0), 2, 0));
    tbl.push_back(mkv(0, 0, 0, 1, 32'h12C, 1, 2, 3, C_ADD, 2'b00, 2'b00, 0, e_v14, 2, 0));
    tbl.push_back(mkv(0, 1, 0, 1, 32'h130, 4, 5, 6, C_ADD, 2'b01, 2'b10, 0, e_v14, 2, 0));
    tbl.push_back(mkv(0, 1, 0, 1, 32'h134, 8, 8, 0, C_LW,  2'b10, 2'b01, 0, e_v14, 2, 0));
    tbl.push_back(mkv(0, 1, 0, 0, 32'h138, 9, 9, 9, C_SW,  2'b01, 2'b01, 0, e_v14, 2, 0));
    tbl.push_back(mkv(0, 1, 1, 1, 32'h13C, 1, 2, 3, C_ADD, 2'b00, 2'b00, 0, e_z, 2, 1));
    tbl.push_back(mkv(0, 0, 0, 1, 32'h140, 1, 8, 0, C_LW, 2'b00, 2'b00, 0,
                      mkexp(1, 32'h140, D_RD1, D_RD2, 1, 8, 0, C_LW), 2, 1));
    tbl.push_back(mkv(0, 0, 1, 1, 32'h144, 8, 8, 4, C_ADD, 2'b00, 2'b00, 1, e_z, 2, 2));
    tbl.push_back(mkv(0, 0, 0, 1, 32'h148, 1, 2, 3, C_ADD, 2'b00, 2'b00, 0,
                      mkexp(1, 32'h148, D_RD1, D_RD2, 1, 2, 3, C_ADD), 2, 2));
    tbl.push_back(mkv(1, 1, 1, 1, 32'h14C, 3, 3, 3, C_LW, 2'b01, 2'b01, 0, e_z, 0, 0));

    // First reset edge establishes a known EX state; the table's own reset
    // vector supplies the second edge and the reset checks.
    drive(tbl[0]);
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("vec%0d lu_stall", i), {152'b0, lu_stall}, {152'b0, tbl[i].exp_lu});
      sb_q.push_back(tbl[i].exp);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL vec%0d scoreboard: got empty queue expected one entry", i);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk($sformatf("vec%0d ex_regs", i), act, e);
      end
      chk($sformatf("vec%0d bubble_inv", i),
          {152'b0, (!ex_valid && (ex_RegWr || ex_MemWr || ex_Branch))}, 153'b0);
`ifdef ID_EX_STATS_EN
      chk($sformatf("vec%0d bubble_cnt", i), {137'b0, bubble_cnt}, {137'b0, tbl[i].exp_bub});
      chk($sformatf("vec%0d flush_cnt", i), {137'b0, flush_cnt}, {137'b0, tbl[i].exp_flu});
`endif
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
